// File: rtl/if_stage_pkg.sv
// Shared CPU constants and the fetch/decode pipeline payload type.
package if_stage_pkg;

    // First fetch address; also the lowest legal instruction address.
    localparam logic [31:0] CPU_PC_RESET = 32'h0000_3000;
    // Instruction memory depth in 32-bit words.
    localparam int          CPU_IM_WORDS = 4096;
    // Encoding used for bubbles and for words fetched from an illegal address.
    localparam logic [31:0] CPU_NOP      = 32'h0000_0000;

    // Contents of the F/D pipeline register.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } fd_t;

    // A bubble carries no instruction, no address and no fault.
    localparam fd_t FD_BUBBLE = '{instr: CPU_NOP, pc: 32'h0, valid: 1'b0, adel: 1'b0};

endpackage

// File: rtl/fd_reg.sv
// F/D pipeline register: reset > stall (hold) > clear (bubble) > load.
module fd_reg
    import if_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_stall,
    input  logic i_clr,
    input  fd_t  i_fd,
    output fd_t  o_fd
);

    fd_t r_fd;

    // Pipeline register update with its own priority chain.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples the pre-edge values regardless of block ordering.
        if (reset) begin
            r_fd <= FD_BUBBLE;
        end else if (i_stall) begin
            r_fd <= r_fd;
        end else if (i_clr) begin
            r_fd <= FD_BUBBLE;
        end else begin
            r_fd <= i_fd;
        end
    end

    assign o_fd = r_fd;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection, illegal-address
// detection and the F/D pipeline register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = CPU_PC_RESET,
    parameter int          IM_WORDS = CPU_IM_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] F_IM_PC,
    input  logic [31:0] F_IM_Instr,
    input  logic        stall,
    input  logic        npc_sel,
    input  logic [31:0] npc_target,
    input  logic        D_clr,
    output logic [31:0] D_Instr,
    output logic [31:0] D_PC,
    output logic        D_valid,
    output logic        D_AdEL
);

    // Highest legal word address, kept 33 bits wide so a window ending at the
    // top of the address space cannot wrap the comparison.
    localparam logic [32:0] PC_LAST = {1'b0, PC_RESET} + (33'(IM_WORDS) * 33'd4) - 33'd4;

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic        w_illegal;
    fd_t         w_fetch;
    fd_t         w_fd;

    // Next-PC selection: stall holds, redirect jumps, otherwise sequential.
    // The redirect does not squash the word in fetch; it still enters F/D.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_pc_next = r_pc;
        if (!stall) begin
            if (npc_sel) begin
                w_pc_next = npc_target;
            end else begin
                w_pc_next = r_pc + 32'd4;
            end
        end
    end

    // PC register; F_IM_PC comes straight from it with no combinational input path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= PC_RESET;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign F_IM_PC = r_pc;

    // Fetch result: a faulting address yields a NOP-valued, flagged instruction.
    always_comb begin
        w_illegal = (r_pc[1:0] != 2'b00) || (r_pc < PC_RESET) || ({1'b0, r_pc} > PC_LAST);
        w_fetch   = '{instr: F_IM_Instr, pc: r_pc, valid: 1'b1, adel: 1'b0};
        if (w_illegal) begin
            w_fetch.instr = CPU_NOP;
            w_fetch.adel  = 1'b1;
        end
    end

    fd_reg u_fd_reg (
        .clk     (clk),
        .reset   (reset),
        .i_stall (stall),
        .i_clr   (D_clr),
        .i_fd    (w_fetch),
        .o_fd    (w_fd)
    );

    assign D_Instr = w_fd.instr;
    assign D_PC    = w_fd.pc;
    assign D_valid = w_fd.valid;
    assign D_AdEL  = w_fd.adel;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage with a combinational instruction memory model.
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic [31:0] F_IM_PC;
    logic [31:0] F_IM_Instr;
    logic        stall;
    logic        npc_sel;
    logic [31:0] npc_target;
    logic        D_clr;
    logic [31:0] D_Instr;
    logic [31:0] D_PC;
    logic        D_valid;
    logic        D_AdEL;

    int checks   = 0;
    int failures = 0;

    if_stage dut (
        .clk        (clk),
        .reset      (reset),
        .F_IM_PC    (F_IM_PC),
        .F_IM_Instr (F_IM_Instr),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .npc_target (npc_target),
        .D_clr      (D_clr),
        .D_Instr    (D_Instr),
        .D_PC       (D_PC),
        .D_valid    (D_valid),
        .D_AdEL     (D_AdEL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed word at 0x3000, address-tagged words elsewhere.
    function automatic logic [31:0] im_word(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 32'h2408_0001 : (32'h8C00_0000 | {16'h0, a[15:0]});
    endfunction

    assign F_IM_Instr = im_word(F_IM_PC);

    // Advance one rising edge and settle 1 ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; npc_sel = 1'b0; npc_target = 32'h0; D_clr = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        stall = 1'b1; npc_sel = 1'b1; npc_target = 32'h1234_5678; D_clr = 1'b0;
        reset = 1'b1;
        step();
        checks++; if (F_IM_PC !== 32'h3000) begin failures++; $display("FAIL reset_pc got=%h exp=%h", F_IM_PC, 32'h3000); end
        checks++; if (D_Instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", D_Instr); end
        checks++; if (D_PC !== 32'h0) begin failures++; $display("FAIL reset_dpc got=%h exp=0", D_PC); end
        checks++; if ({D_valid, D_AdEL} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b exp=00", {D_valid, D_AdEL}); end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (F_IM_PC !== 32'h3000 + 32'(4 * i)) begin
                failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, F_IM_PC, 32'h3000 + 32'(4 * i));
            end
            if (i == 1) begin
                checks++;
                if ({D_Instr, D_PC, D_valid, D_AdEL} !== {32'h2408_0001, 32'h3000, 2'b10}) begin
                    failures++; $display("FAIL seq_first_d got=%h/%h/%b%b exp=24080001/00003000/10", D_Instr, D_PC, D_valid, D_AdEL);
                end
            end
            if (i == 3) begin
                checks++;
                if ({D_Instr, D_PC} !== {32'h8C00_3008, 32'h3008}) begin
                    failures++; $display("FAIL seq_third_d got=%h/%h exp=8c003008/00003008", D_Instr, D_PC);
                end
            end
            step();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step(); step();
        npc_sel = 1'b1; npc_target = 32'h3040;
        step();
        npc_sel = 1'b0;
        checks++; if ({D_PC, D_Instr, D_valid} !== {32'h3008, 32'h8C00_3008, 1'b1}) begin failures++; $display("FAIL redir_delay_slot got=%h/%h/%b exp=00003008/8c003008/1", D_PC, D_Instr, D_valid); end
        checks++; if (F_IM_PC !== 32'h3040) begin failures++; $display("FAIL redir_pc got=%h exp=00003040", F_IM_PC); end
        step();
        checks++; if ({F_IM_PC, D_PC} !== {32'h3044, 32'h3040}) begin failures++; $display("FAIL redir_after got=%h/%h exp=00003044/00003040", F_IM_PC, D_PC); end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step(); step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({F_IM_PC, D_Instr, D_PC, D_valid, D_AdEL} !== {32'h3010, 32'h8C00_300C, 32'h300C, 2'b10}) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h/%h/%h/%b%b exp=00003010/8c00300c/0000300c/10", i, F_IM_PC, D_Instr, D_PC, D_valid, D_AdEL);
            end
        end
        stall = 1'b0;
        step();
        checks++; if ({F_IM_PC, D_PC} !== {32'h3014, 32'h3010}) begin failures++; $display("FAIL stall_release got=%h/%h exp=00003014/00003010", F_IM_PC, D_PC); end
        // Stall beats redirect and clear in the same cycle.
        stall = 1'b1; npc_sel = 1'b1; npc_target = 32'h3080; D_clr = 1'b1;
        step();
        checks++; if ({F_IM_PC, D_PC, D_valid} !== {32'h3014, 32'h3010, 1'b1}) begin failures++; $display("FAIL stall_prio got=%h/%h/%b exp=00003014/00003010/1", F_IM_PC, D_PC, D_valid); end
        stall = 1'b0; npc_sel = 1'b0;
        step();
        D_clr = 1'b0;
        checks++; if ({D_valid, D_Instr, D_PC, D_AdEL} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin failures++; $display("FAIL clr_bubble got=%b/%h/%h/%b exp=0/0/0/0", D_valid, D_Instr, D_PC, D_AdEL); end
        checks++; if (F_IM_PC !== 32'h3018) begin failures++; $display("FAIL clr_pc got=%h exp=00003018", F_IM_PC); end
    endtask

    task automatic test_illegal();
        do_reset();
        npc_sel = 1'b1; npc_target = 32'h3002;
        step();
        npc_target = 32'h2FFC;
        step();
        checks++; if ({D_AdEL, D_valid, D_Instr, D_PC} !== {2'b11, 32'h0, 32'h3002}) begin failures++; $display("FAIL adel_misaligned got=%b%b/%h/%h exp=11/0/00003002", D_AdEL, D_valid, D_Instr, D_PC); end
        npc_target = 32'h7000;
        step();
        checks++; if ({D_AdEL, D_valid, D_Instr, D_PC} !== {2'b11, 32'h0, 32'h2FFC}) begin failures++; $display("FAIL adel_below got=%b%b/%h/%h exp=11/0/00002ffc", D_AdEL, D_valid, D_Instr, D_PC); end
        npc_target = 32'h6FFC;
        step();
        checks++; if ({D_AdEL, D_valid, D_Instr, D_PC} !== {2'b11, 32'h0, 32'h7000}) begin failures++; $display("FAIL adel_above got=%b%b/%h/%h exp=11/0/00007000", D_AdEL, D_valid, D_Instr, D_PC); end
        npc_sel = 1'b0;
        step();
        checks++; if ({D_AdEL, D_valid, D_Instr, D_PC} !== {2'b01, 32'h8C00_6FFC, 32'h6FFC}) begin failures++; $display("FAIL last_legal got=%b%b/%h/%h exp=01/8c006ffc/00006ffc", D_AdEL, D_valid, D_Instr, D_PC); end
        checks++; if (F_IM_PC !== 32'h7000) begin failures++; $display("FAIL no_halt_pc got=%h exp=00007000", F_IM_PC); end
        npc_sel = 1'b1; npc_target = 32'hFFFF_FFFC;
        step();
        npc_sel = 1'b0;
        step();
        checks++; if ({F_IM_PC, D_PC, D_AdEL} !== {32'h0, 32'hFFFF_FFFC, 1'b1}) begin failures++; $display("FAIL wrap got=%h/%h/%b exp=00000000/fffffffc/1", F_IM_PC, D_PC, D_AdEL); end
    endtask

    task automatic test_reset_sync();
        do_reset();
        step();
        reset = 1'b1;
        #2;
        checks++; if ({F_IM_PC, D_PC, D_valid} !== {32'h3004, 32'h3000, 1'b1}) begin failures++; $display("FAIL reset_async_ignored got=%h/%h/%b exp=00003004/00003000/1", F_IM_PC, D_PC, D_valid); end
        step();
        checks++; if ({F_IM_PC, D_valid} !== {32'h3000, 1'b0}) begin failures++; $display("FAIL reset_at_edge got=%h/%b exp=00003000/0", F_IM_PC, D_valid); end
        reset = 1'b0;
    endtask

    task automatic test_reset_override();
        do_reset();
        npc_sel = 1'b1; npc_target = 32'h3100;
        step();
        npc_sel = 1'b0; stall = 1'b1;
        step();
        checks++; if (F_IM_PC !== 32'h3100) begin failures++; $display("FAIL ovr_setup got=%h exp=00003100", F_IM_PC); end
        reset = 1'b1; npc_sel = 1'b1; npc_target = 32'h3200; D_clr = 1'b1;
        step();
        checks++; if ({F_IM_PC, D_valid, D_PC} !== {32'h3000, 1'b0, 32'h0}) begin failures++; $display("FAIL ovr_reset got=%h/%b/%h exp=00003000/0/00000000", F_IM_PC, D_valid, D_PC); end
        reset = 1'b0; stall = 1'b0; npc_sel = 1'b0; D_clr = 1'b0;
        step();
        checks++; if ({F_IM_PC, D_PC, D_Instr, D_valid} !== {32'h3004, 32'h3000, 32'h2408_0001, 1'b1}) begin failures++; $display("FAIL ovr_resume got=%h/%h/%h/%b exp=00003004/00003000/24080001/1", F_IM_PC, D_PC, D_Instr, D_valid); end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; npc_sel = 1'b0; npc_target = 32'h0; D_clr = 1'b0;
        #1;
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_illegal();
        test_reset_sync();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_RESET, default 32'h0000_3000, meaning first fetch address and lowest legal instruction address.
REQ-002 Parameter IM_WORDS, default 4096, meaning instruction memory depth in words; legal range is PC_RESET to PC_RESET+4*IM_WORDS-4.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 F_IM_PC  out  32  current fetch address, driven to instruction memory.
REQ-006 F_IM_Instr  in  32  instruction word returned combinationally by instruction memory for F_IM_PC.
REQ-007 stall  in  1  hazard hold from decode; freezes PC and F/D register.
REQ-008 npc_sel  in  1  decode-stage redirect (branch taken / jump) valid this cycle.
REQ-009 npc_target  in  32  redirect target address; meaningful only when npc_sel=1.
REQ-010 D_clr  in  1  clears F/D register to a bubble.
REQ-011 D_Instr  out  32  instruction latched into decode.
REQ-012 D_PC  out  32  address of D_Instr.
REQ-013 D_valid  out  1  D_Instr is a real fetched instruction, not a bubble.
REQ-014 D_AdEL  out  1  D_Instr came from an illegal fetch address.

Function
REQ-015 PC register SHALL drive F_IM_PC directly, with no combinational path from any input.
REQ-016 Next PC, priority high to low: reset -> PC_RESET; stall -> hold; npc_sel -> npc_target; else PC+4 (32-bit, wraps modulo 2^32).
REQ-017 Redirect SHALL NOT squash the instruction currently in fetch: it enters F/D normally (branch delay slot).
REQ-018 F/D register update, priority high to low: reset -> bubble; stall -> hold all of D_Instr/D_PC/D_valid/D_AdEL; D_clr -> bubble; else load fetch results.
REQ-019 Bubble SHALL be D_Instr=32'h0, D_PC=32'h0, D_valid=0, D_AdEL=0.
REQ-020 Illegal fetch: PC[1:0]!=0, PC<PC_RESET, or PC>PC_RESET+4*IM_WORDS-4.
REQ-021 On illegal fetch, loaded D_Instr SHALL be 32'h0, D_PC the faulting PC, D_valid=1, D_AdEL=1; F_IM_Instr is ignored.
REQ-022 On legal fetch, loaded D_Instr=F_IM_Instr, D_PC=PC, D_valid=1, D_AdEL=0.
REQ-023 stall with npc_sel=1 in the same cycle: stall wins, the redirect is dropped; decode re-asserts it once stall falls.
REQ-024 stall with D_clr in the same cycle: stall wins, F/D holds.
REQ-025 Fetch latency: instruction at PC appears on D_Instr the cycle after PC is presented, absent stall.
REQ-026 Next PC after an illegal fetch follows REQ-016 unchanged; no internal halt.

Reset
REQ-027 Reset SHALL be sampled only on rising clk; asynchronous assertion has no effect before the edge.
REQ-028 After reset edge: F_IM_PC=PC_RESET, D_Instr=0, D_PC=0, D_valid=0, D_AdEL=0.
REQ-029 Reset asserted mid-stall or mid-redirect SHALL override both with no residual state.

Structure
REQ-030 PC_RESET, IM_WORDS default, and NOP encoding (32'h0) SHALL live in the shared CPU constants package.
REQ-031 The F/D pipeline register SHALL be one sub-module, fd_reg, with its own stall/clr/reset priority; PC logic stays in if_stage.

Verification
REQ-032 Reset then 4 free cycles, IM returns 32'h2408_0001 at 0x3000 -> F_IM_PC 0x3000,0x3004,0x3008,0x300C; D_Instr=32'h2408_0001, D_PC=0x3000, D_valid=1 in cycle 2.
REQ-033 npc_sel=1, npc_target=0x3040 while PC=0x3008 -> D_PC=0x3008 next (delay slot kept), then F_IM_PC=0x3040.
REQ-034 stall=1 for 3 cycles at PC=0x3010 -> F_IM_PC and all D_* outputs constant; PC=0x3014 one cycle after stall falls.
REQ-035 stall=1, npc_sel=1, D_clr=1 together -> PC and F/D hold; stall=0, D_clr=1 -> D_valid=0, D_Instr=0.
REQ-036 npc_target=0x3002, then 0x2FFC, then 0x7000 (IM_WORDS=4096) -> each loads D_AdEL=1, D_Instr=0, D_PC=faulting address.
REQ-037 Reset asserted while stall=1 at PC=0x3100 -> next edge F_IM_PC=0x3000, D_valid=0.
